// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: forwarding selects, load-use/MDU scoreboard stalls, branch flushes.
// Optional performance counters (stallCnt, flushCnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int MAX_OUT  = 4,
    parameter int PERF_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            r1AddrD,
    input  logic [ADDR_W-1:0]            r2AddrD,
    input  logic [ADDR_W-1:0]            rdD,
    input  logic                         mdOpD,
    input  logic [ADDR_W-1:0]            r1AddrE,
    input  logic [ADDR_W-1:0]            r2AddrE,
    input  logic [ADDR_W-1:0]            rdE,
    input  logic                         regSrcE0,
    input  logic                         mdIssueE,
    input  logic                         wrongBranchE,
    input  logic [ADDR_W-1:0]            rdM,
    input  logic [ADDR_W-1:0]            rdW,
    input  logic                         regWriteM,
    input  logic                         regWriteW,
    input  logic                         mdDoneW,
    input  logic [ADDR_W-1:0]            mdRdW,
    output logic [1:0]                   fwdAE,
    output logic [1:0]                   fwdBE,
    output logic                         stallF,
    output logic                         stallD,
    output logic                         flushD,
    output logic                         flushE,
    output logic [$clog2(MAX_OUT+1)-1:0] outCnt
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]            stallCnt,
    output logic [PERF_W-1:0]            flushCnt
`endif
);

    localparam int CNT_W = $clog2(MAX_OUT+1);

    if (MAX_OUT < 1 || MAX_OUT > 15 || PERF_W < 1) begin : g_param_check
        $error("hazard_scoreboard: MAX_OUT must be 1..15 and PERF_W positive");
    end

    logic [NUM_REGS-1:1] pend_q, pend_d;
    logic [NUM_REGS-1:0] pen_eff;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_eff;
    logic                lw_stall, sb_stall, cap_stall, stall;
    logic signed [CNT_W+1:0] cap_sum;

    // Forwarding: memory stage wins over writeback.
    always_comb begin
        fwdAE = 2'b00;
        fwdBE = 2'b00;
        if (regWriteM && rdM != '0 && rdM == r1AddrE)      fwdAE = 2'b10;
        else if (regWriteW && rdW != '0 && rdW == r1AddrE) fwdAE = 2'b01;
        if (regWriteM && rdM != '0 && rdM == r2AddrE)      fwdBE = 2'b10;
        else if (regWriteW && rdW != '0 && rdW == r2AddrE) fwdBE = 2'b01;
    end

    // Next pend equals the effective pending view: a completing register is
    // readable this cycle, an issuing one is already busy, and set beats clear.
    always_comb begin
        pend_d = pend_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            pend_d[r] = (mdIssueE && rdE == ADDR_W'(r)) ||
                        (pend_q[r] && !(mdDoneW && mdRdW == ADDR_W'(r)));
        end
        pen_eff = {pend_d, 1'b0};
    end

    always_comb begin
        done_eff = mdDoneW && (cnt_q != '0);
        cnt_d    = cnt_q;
        if (mdIssueE && !done_eff) begin
            if (cnt_q != CNT_W'(MAX_OUT)) cnt_d = cnt_q + CNT_W'(1);
        end else if (!mdIssueE && done_eff) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        cap_sum   = $signed({2'b00, cnt_q})
                  + $signed({{(CNT_W+1){1'b0}}, mdIssueE})
                  - $signed({{(CNT_W+1){1'b0}}, mdDoneW});
        lw_stall  = regSrcE0 && rdE != '0 && (r1AddrD == rdE || r2AddrD == rdE);
        sb_stall  = pen_eff[r1AddrD] || pen_eff[r2AddrD] || pen_eff[rdD];
        cap_stall = mdOpD && (cap_sum >= $signed((CNT_W+2)'(MAX_OUT)));
        stall     = lw_stall || sb_stall || cap_stall;
    end

    assign stallD = stall;
    assign stallF = stall;
    assign flushE = stall || wrongBranchE;
    assign flushD = wrongBranchE;
    assign outCnt = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + PERF_W'(stall);
        flush_cnt_d = flush_cnt_q + PERF_W'(wrongBranchE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCnt = stall_cnt_q;
    assign flushCnt = flush_cnt_q;
`endif

endmodule
